// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU-priority access with a streak guard that grants the
// debug/loader port after MAX_STREAK back-to-back CPU grants, plus tagged read return.
module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic                OWNER_CPU  = 1'b0;
  localparam logic                OWNER_DBG  = 1'b1;

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_owner_q, rd_owner_d;
  logic                dbg_sel, cpu_sel;

  // Grants are gated by rst so nothing reaches memory while reset is held.
  assign dbg_sel = ~rst & dbg_req & (~cpu_req | (streak_q == STREAK_MAX));
  assign cpu_sel = ~rst & cpu_req & ~dbg_sel;

  assign cpu_gnt = cpu_sel;
  assign dbg_gnt = dbg_sel;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_sel) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_sel) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (cpu_sel && dbg_req) begin
      if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
    end else if (cpu_sel || dbg_sel) begin
      streak_d = '0;
    end
  end

  always_comb begin
    rd_pend_d  = mem_en & ~mem_we;
    rd_owner_d = rd_owner_q;
    if (rd_pend_d) rd_owner_d = dbg_sel ? OWNER_DBG : OWNER_CPU;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_CPU;
    end else begin
      streak_q   <= streak_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid = rd_pend_q & (rd_owner_q == OWNER_CPU);
  assign dbg_rvalid = rd_pend_q & (rd_owner_q == OWNER_DBG);
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single-port data memory between the CPU load/store stage and a debug/loader port used to preload or inspect memory while the core runs. CPU has priority. A streak counter guarantees the debug port a slot after MAX_STREAK back-to-back CPU grants while debug waits. The block sits between the core's memory stage, the debug port and the data memory, and returns tagged read data one cycle after each granted read.

Parameters:
ADDR_W, 10, word address width into data memory
DATA_W, 32, data word width
MAX_STREAK, 4, max consecutive CPU grants while dbg_req is pending (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  CPU access request; held stable until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle (combinational)
cpu_rvalid  out  1  CPU read data valid (registered)
cpu_rdata  out  DATA_W  CPU read data
dbg_req  in  1  debug access request; held stable until dbg_gnt
dbg_we  in  1  1 = write, 0 = read
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug access accepted this cycle (combinational)
dbg_rvalid  out  1  debug read data valid (registered)
dbg_rdata  out  DATA_W  debug read data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid one cycle after read enable

Behaviour:
- Reset (async, rst=1): streak=0, rd_pend=0, rd_owner=0, cpu_rvalid=dbg_rvalid=0. Gnt/mem_* outputs are forced to 0 while rst=1. A read in flight when reset asserts is dropped; no rvalid is produced for it after reset.
- Grant (combinational, at most one per cycle):
  - dbg_sel = dbg_req & (~cpu_req | streak==MAX_STREAK).
  - cpu_gnt = cpu_req & ~dbg_sel.
  - dbg_gnt = dbg_sel.
- Memory drive:
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted side.
  - With no grant, mem_en=0, mem_we=0, addr/wdata=0.
- Streak counter, updated on rising clk:
  - cpu_gnt & dbg_req: streak <= streak+1, saturating at MAX_STREAK.
  - cpu_gnt & ~dbg_req: streak <= 0.
  - dbg_gnt: streak <= 0.
  - No grant: hold.
- Read return, 1-cycle latency:
  - On a granted read (mem_en & ~mem_we): rd_pend <= 1 and rd_owner <= granted side. Otherwise rd_pend <= 0.
  - cpu_rvalid = rd_pend & rd_owner==CPU; dbg_rvalid = rd_pend & rd_owner==DBG. Both come from registers.
  - cpu_rdata and dbg_rdata both carry mem_rdata. They are meaningful only while the matching rvalid is high.
- Writes complete in the grant cycle; no response is produced.
- Back-to-back grants are allowed every cycle. A read on one side followed next cycle by a grant to the other side is legal: rvalid for the first read and the new grant coincide.
- A requester not granted keeps req/we/addr/wdata stable. Behaviour is undefined if a requester changes them before its grant.
- Simultaneous requests, streak<MAX_STREAK: CPU wins. At streak==MAX_STREAK: debug wins exactly one cycle, then CPU priority resumes.
- Throughput is 1 access/cycle with no bubbles inserted.

Test Plan:
- Reset/idle: rst held high 27 ns, no requests -> all gnt/rvalid/mem_en = 0. After reset release, mem_en stays 0.
- CPU read/write: CPU write addr 0x010 data 0xDEADBEEF (gnt same cycle, mem_we=1), then read 0x010 -> cpu_rvalid=1 next cycle with cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- Priority: cpu_req and dbg_req both high in one cycle, streak=0 -> cpu_gnt=1, dbg_gnt=0. cpu_req drops next cycle -> dbg_gnt=1.
- Starvation guard: cpu_req held high with reads 0x000..0x007, dbg read 0x020 pending, MAX_STREAK=4 -> 4 CPU grants, dbg_gnt on cycle 5, CPU again on cycle 6. dbg_rvalid=1 on cycle 6 with the word at 0x020.
- Interleaved reads: CPU read 0x001 then dbg read 0x002 in consecutive cycles -> cpu_rvalid then dbg_rvalid, each with the correct word and no overlap.
- Reset mid-read: assert rst in the cycle after a granted CPU read -> cpu_rvalid=0 immediately. Streak=0 after release, and no stale rvalid appears.
